stream_mux_rr: RTL

- Parametrised N-channel, W-bit multiplexer with valid/ready handshakes; generalises the team's 2:1 combinational muxes.
- Each cycle, one input channel is selected, either by an explicit select (manual mode) or by round-robin arbitration.
- The selected beat is registered onto a single output stream.
- Sits between multiple producer streams and one shared consumer, such as a shared bus or a UART TX path.

---
 rtl/stream_mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/stream_mux_rr.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package stream_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    localparam int   MAX_N       = 16;

    // A one-hot input needs no priority: OR-ing the set positions yields the index.
    function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: request vector plus start pointer -> one-hot grant and index.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none, the parent gates the grant with its accept condition.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx
);

    logic [SW-1:0]    cand;
    logic             found;
    logic [MAX_N-1:0] grant_pad;

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = SW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        grant_pad        = '0;
        grant_pad[N-1:0] = grant;
    end

    assign idx = SW'(onehot_to_idx(grant_pad));

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux, manual or round-robin select; STREAM_MUX_LOCK_EN adds packet lock.
// Latency: 1 cycle from input transfer to registered output beat.
// Backpressure: single output register; all in_ready drop while a beat is held with out_ready low.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    output logic            out_last,
    input  logic            out_ready
);

    logic          accept;
    logic          xfer;
    logic          ptr_adv;
    logic          mux_last;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  man_grant;
    logic [N-1:0]  grant;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_idx;
    logic [SW-1:0] gidx;
    logic [SW-1:0] nxt_ptr;
    logic [W-1:0]  mux_data;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Out-of-range select values (possible when N is not a power of two) grant nothing.
    always_comb begin
        man_grant = '0;
        if (int'(sel) < N) man_grant[sel] = in_valid[sel];
    end

`ifdef STREAM_MUX_LOCK_EN
    logic          lock;
    logic [SW-1:0] lock_chan;

    always_comb begin
        grant = '0;
        gidx  = '0;
        if (lock) begin
            grant[lock_chan] = in_valid[lock_chan];
            gidx             = lock_chan;
        end else if (mode == MODE_RR) begin
            grant = rr_grant;
            gidx  = rr_idx;
        end else begin
            grant = man_grant;
            gidx  = sel;
        end
    end

    assign mux_last = |(grant & in_last);
    assign ptr_adv  = xfer && (mode == MODE_RR) && mux_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock      <= 1'b0;
            lock_chan <= '0;
        end else if (xfer) begin
            lock      <= !mux_last;
            lock_chan <= gidx;
        end
    end
`else
    logic unused_in_last;

    always_comb begin
        grant = '0;
        gidx  = '0;
        if (mode == MODE_RR) begin
            grant = rr_grant;
            gidx  = rr_idx;
        end else begin
            grant = man_grant;
            gidx  = sel;
        end
    end

    assign unused_in_last = |in_last;
    assign mux_last       = 1'b0;
    assign ptr_adv        = xfer && (mode == MODE_RR);
`endif

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) mux_data = mux_data | in_data[i*W +: W];
        end
    end

    assign accept   = !out_valid || out_ready;
    assign xfer     = accept && (|grant);
    assign in_ready = (accept && !rst) ? grant : '0;
    assign nxt_ptr  = (gidx == SW'(N-1)) ? '0 : gidx + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_chan  <= gidx;
                out_last  <= mux_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (ptr_adv) rr_ptr <= nxt_ptr;
        end
    end

endmodule
